// File: rtl/lsu_wb_master.sv
// -----------------------------------------------------------------------------
// lsu_wb_master
//
// Load/store unit bus master sitting behind MEM1. Each single-cycle request
// (pre-formatted write data and byte selects) becomes exactly one pipelined
// Wishbone B4 transaction. The raw 32-bit read word comes back with a one-cycle
// done pulse. MEM1 performs alignment and sign extension. Only one transaction
// is outstanding at a time.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   - a cycle counter forces completion with bus_err_o=1 after
//               TIMEOUT_CYCLES cycles of cyc without ack/err.
//   undefined - no counter. The unit waits indefinitely for ack/err.
//
// Parameters
//   TIMEOUT_CYCLES  cycles from cyc rise to forced bus error (timeout build only)
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_i                request pulse. addr_i/we_i/wsel_byte_i/wdata_i valid with it
//   addr_i               byte address (word-aligned onto the bus)
//   we_i                 1 = store, 0 = load
//   wsel_byte_i          store byte enables (loads always use 4'b1111)
//   wdata_i              lane-aligned store data
//   req_stall_o          high while a transaction is in flight
//   rdata_o              raw read word, updated on load ack, held otherwise
//   req_done_o           one-cycle completion pulse
//   bus_err_o            qualifies req_done_o: ended in error or timeout
//   wb_cyc_o .. wb_dat_o Wishbone master outputs (all registered)
//   wb_dat_i, wb_stall_i, wb_ack_i, wb_err_i  Wishbone slave responses
// -----------------------------------------------------------------------------
module lsu_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  wsel_byte_i,
    input  logic [31:0] wdata_i,
    output logic        req_stall_o,
    output logic [31:0] rdata_o,
    output logic        req_done_o,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,   // stb asserted, waiting for the slave to take it
        WAIT = 2'd2    // stb taken, waiting for ack/err
    } state_t;

    state_t      state_reg, state_next;
    logic        cyc_reg, cyc_next;
    logic        stb_reg, stb_next;
    logic        we_reg, we_next;
    logic [3:0]  sel_reg, sel_next;
    logic [31:0] adr_reg, adr_next;
    logic [31:0] dat_reg, dat_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        done_reg, done_next;
    logic        berr_reg, berr_next;

    logic        capture;
    logic        resp_done;
    logic        timeout_done;
    logic        timeout_hit;

    // Byte offset is irrelevant on a 32-bit bus; the slave sees word addresses.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // The counter holds k-1 during the k-th cycle of cyc, so matching
    // TIMEOUT_CYCLES-1 completes on the TIMEOUT_CYCLES-th cycle and done
    // appears TIMEOUT_CYCLES cycles after cyc rose.
    assign timeout_hit = cyc_reg && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_next = cnt_reg;
        if (capture) begin
            cnt_next = '0;
        end else if (cyc_reg) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        stb_next     = stb_reg;
        we_next      = we_reg;
        sel_next     = sel_reg;
        adr_next     = adr_reg;
        dat_next     = dat_reg;
        rdata_next   = rdata_reg;
        done_next    = 1'b0;
        berr_next    = 1'b0;
        capture      = 1'b0;
        resp_done    = 1'b0;
        timeout_done = 1'b0;

        case (state_reg)
            IDLE: begin
                // Stray ack/err while idle are deliberately ignored.
                if (req_i) begin
                    capture    = 1'b1;
                    we_next    = we_i;
                    sel_next   = we_i ? wsel_byte_i : 4'b1111;
                    adr_next   = {addr_i[31:2], 2'b00};
                    dat_next   = wdata_i;
                    cyc_next   = 1'b1;
                    stb_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // A response only counts once the strobe is accepted
                // (stall low); a slave may answer in the acceptance cycle.
                if (!wb_stall_i && (wb_ack_i || wb_err_i)) begin
                    resp_done = 1'b1;
                end else if (timeout_hit) begin
                    timeout_done = 1'b1;
                end else if (!wb_stall_i) begin
                    stb_next   = 1'b0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wb_ack_i || wb_err_i) begin
                    resp_done = 1'b1;
                end else if (timeout_hit) begin
                    timeout_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = 1'b0;
                stb_next   = 1'b0;
            end
        endcase

        if (resp_done || timeout_done) begin
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
            // Error has priority over ack; only a clean load ack updates rdata.
            berr_next  = timeout_done || wb_err_i;
            if (resp_done && !wb_err_i && !we_reg) begin
                rdata_next = wb_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= 4'b0;
            adr_reg   <= 32'h0;
            dat_reg   <= 32'h0;
            rdata_reg <= 32'h0;
            done_reg  <= 1'b0;
            berr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            stb_reg   <= stb_next;
            we_reg    <= we_next;
            sel_reg   <= sel_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            rdata_reg <= rdata_next;
            done_reg  <= done_next;
            berr_reg  <= berr_next;
        end
    end

    assign req_stall_o = (state_reg != IDLE);
    assign rdata_o     = rdata_reg;
    assign req_done_o  = done_reg;
    assign bus_err_o   = berr_reg;
    assign wb_cyc_o    = cyc_reg;
    assign wb_stb_o    = stb_reg;
    assign wb_we_o     = we_reg;
    assign wb_sel_o    = sel_reg;
    assign wb_adr_o    = adr_reg;
    assign wb_dat_o    = dat_reg;

`ifndef SYNTHESIS
    // MEM1 must honour req_stall_o; a request while busy is dropped.
    a_no_req_while_busy : assert property (
        @(posedge clk_i) disable iff (rst_i) !(req_i && state_reg != IDLE)
    ) else $warning("lsu_wb_master: req_i while busy, request dropped");
`endif

endmodule

// File: tb/tb_lsu_wb_master.sv
module tb_lsu_wb_master;

    localparam int TO = 8;
`ifdef LSU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  wsel_byte_i = '0;
    logic [31:0] wdata_i = '0;
    logic        req_stall_o;
    logic [31:0] rdata_o;
    logic        req_done_o;
    logic        bus_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_stall_i = 1'b0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    always #5 clk_i = ~clk_i;

    lsu_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
        .we_i(we_i), .wsel_byte_i(wsel_byte_i), .wdata_i(wdata_i),
        .req_stall_o(req_stall_o), .rdata_o(rdata_o), .req_done_o(req_done_o),
        .bus_err_o(bus_err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_stall_i(wb_stall_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one outstanding request, its latched bus
    // fields, whether the strobe was taken, and how long cyc has been up.
    bit          m_busy, m_taken, m_we, m_done, m_err;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat, m_rdata;
    int          m_age;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_taken = 0; m_we = 0; m_done = 0; m_err = 0;
        m_sel = '0; m_adr = '0; m_dat = '0; m_rdata = '0; m_age = 0;
    endtask

    // Applies one clock edge's worth of the rules to the model, using the
    // inputs currently being driven.
    task automatic model_edge();
        bit responded;
        m_done = 0;
        m_err  = 0;
        if (rst_i) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (req_i) begin
                m_busy  = 1;
                m_taken = 0;
                m_age   = 0;
                m_we    = we_i;
                m_sel   = we_i ? wsel_byte_i : 4'hF;
                m_adr   = addr_i & 32'hFFFF_FFFC;
                m_dat   = wdata_i;
            end
            return;
        end
        m_age++;
        responded = (m_taken || !wb_stall_i) && (wb_ack_i || wb_err_i);
        if (responded) begin
            m_busy = 0;
            m_done = 1;
            m_err  = wb_err_i;
            if (!m_we && !wb_err_i) m_rdata = wb_dat_i;
        end else if (TO_EN && m_age == TO) begin
            m_busy = 0;
            m_done = 1;
            m_err  = 1;
        end else if (!wb_stall_i) begin
            m_taken = 1;
        end
    endtask

    task automatic compare();
        chk("req_stall", {31'b0, req_stall_o}, {31'b0, m_busy});
        chk("cyc",       {31'b0, wb_cyc_o},    {31'b0, m_busy});
        chk("stb",       {31'b0, wb_stb_o},    {31'b0, m_busy && !m_taken});
        chk("we",        {31'b0, wb_we_o},     {31'b0, m_we});
        chk("sel",       {28'b0, wb_sel_o},    {28'b0, m_sel});
        chk("adr",       wb_adr_o,             m_adr);
        chk("dat_o",     wb_dat_o,             m_dat);
        chk("rdata",     rdata_o,              m_rdata);
        chk("done",      {31'b0, req_done_o},  {31'b0, m_done});
        chk("bus_err",   {31'b0, bus_err_o},   {31'b0, m_err});
        if (req_done_o)
            $display("txn adr=%h we=%0b sel=%h rdata=%h bus_err=%0b",
                     wb_adr_o, wb_we_o, wb_sel_o, rdata_o, bus_err_o);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        compare();
    endtask

    task automatic quiet();
        req_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0;
    endtask

    task automatic request(input logic [31:0] a, input logic w,
                           input logic [3:0] s, input logic [31:0] d);
        req_i = 1; addr_i = a; we_i = w; wsel_byte_i = s; wdata_i = d;
    endtask

    initial begin
        int n;
        model_reset();
        quiet();
        #12;
        chk("reset_cyc",   {31'b0, wb_cyc_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Load, no stall, ack in the strobe cycle.
        request(32'h1000, 1'b0, 4'h3, 32'h5555_5555);
        step();
        chk("t1_stb", {31'b0, wb_stb_o}, 32'd1);
        chk("t1_adr", wb_adr_o, 32'h1000);
        chk("t1_sel", {28'b0, wb_sel_o}, 32'hF);
        quiet(); wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF;
        step();
        chk("t1_done",  {31'b0, req_done_o}, 32'd1);
        chk("t1_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("t1_err",   {31'b0, bus_err_o}, 32'd0);
        quiet(); step();

        // Store with three stalled strobe cycles.
        request(32'h2003, 1'b1, 4'b1000, 32'hAB00_0000);
        step();
        req_i = 0;
        for (int i = 0; i < 3; i++) begin
            wb_stall_i = 1;
            step();
            chk("t2_stb_held", {31'b0, wb_stb_o}, 32'd1);
            chk("t2_adr", wb_adr_o, 32'h2000);
        end
        wb_stall_i = 0;
        step();
        chk("t2_stb_drop", {31'b0, wb_stb_o}, 32'd0);
        wb_ack_i = 1;
        step();
        chk("t2_done",  {31'b0, req_done_o}, 32'd1);
        chk("t2_rdata", rdata_o, 32'hDEAD_BEEF);
        quiet(); step();

        // ack and err together: err wins, rdata untouched.
        request(32'h3004, 1'b0, 4'h0, 32'h0);
        step();
        quiet(); wb_ack_i = 1; wb_err_i = 1; wb_dat_i = 32'h1234_5678;
        step();
        chk("t3_done",  {31'b0, req_done_o}, 32'd1);
        chk("t3_err",   {31'b0, bus_err_o}, 32'd1);
        chk("t3_rdata", rdata_o, 32'hDEAD_BEEF);
        quiet(); step();

        // Request while busy is dropped.
        request(32'h4000, 1'b0, 4'h0, 32'h0);
        step();
        wb_stall_i = 1;
        request(32'h5000, 1'b1, 4'h1, 32'h77);
        step();
        chk("t4_adr", wb_adr_o, 32'h4000);
        quiet();
        step();
        wb_ack_i = 1; wb_dat_i = 32'hCAFE_F00D;
        step();
        chk("t4_rdata", rdata_o, 32'hCAFE_F00D);
        quiet();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_second_cyc", {31'b0, wb_cyc_o}, 32'd0);
        end

        // Async reset while waiting for ack.
        request(32'h6000, 1'b0, 4'h0, 32'h0);
        step();
        quiet();
        step();
        chk("t5_wait", {30'b0, wb_cyc_o, wb_stb_o}, 32'b10);
        #2 rst_i = 1'b1;
        #1;
        chk("t5_cyc_async",  {31'b0, wb_cyc_o}, 32'd0);
        chk("t5_done_async", {31'b0, req_done_o}, 32'd0);
        wb_ack_i = 1;
        step();
        rst_i = 1'b0;
        quiet();
        step();
        request(32'h7000, 1'b0, 4'h0, 32'h0);
        step();
        quiet(); wb_ack_i = 1; wb_dat_i = 32'h1122_3344;
        step();
        chk("t5_after_rst", rdata_o, 32'h1122_3344);
        quiet(); step();

`ifdef LSU_TIMEOUT_EN
        // Silent slave: forced error TO cycles after cyc rises.
        request(32'h8000, 1'b0, 4'h0, 32'h0);
        step();
        quiet();
        n = 0;
        while (!req_done_o && n < 40) begin
            wb_stall_i = ($urandom_range(0, 1) == 0);
            step();
            n++;
        end
        chk("t6_latency", n, TO);
        chk("t6_err", {31'b0, bus_err_o}, 32'd1);
        quiet(); wb_ack_i = 1;
        step();
        chk("t6_late_ack", {31'b0, req_done_o}, 32'd0);
        quiet(); step();
`endif

        // Random traffic, including stray responses while idle.
        for (int i = 0; i < 800; i++) begin
            req_i = (!m_busy && $urandom_range(0, 2) == 0);
            addr_i = $urandom;
            we_i = $urandom_range(0, 1);
            wsel_byte_i = 4'($urandom);
            wdata_i = $urandom;
            wb_stall_i = ($urandom_range(0, 2) == 0);
            wb_ack_i = ($urandom_range(0, 3) == 0);
            wb_err_i = ($urandom_range(0, 15) == 0);
            wb_dat_i = $urandom;
            step();
        end
        quiet();
        n = 0;
        while (m_busy && n < 50) begin
            wb_ack_i = 1;
            step();
            n++;
        end
        chk("drain", {31'b0, m_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
